issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard_pkg.sv | 13 +
 rtl/issue_scoreboard_hazard_check.sv | 21 ++
 rtl/issue_scoreboard.sv | 123 ++++++++++++
 tb/tb_issue_scoreboard.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the dual-issue register scoreboard.
package issue_scoreboard_pkg;

  localparam int unsigned NUM_REGS_DEF = 8;
  localparam int unsigned REG_IDX_W    = 3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage : issue_scoreboard_pkg

// File: rtl/issue_scoreboard_hazard_check.sv
// One lane's operand/destination check against the pending-write vector.
module hazard_check
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic [NUM_REGS-1:0]  busy_i,
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic                 use2_i,
  input  logic                 wr_i,
  output logic                 hazard_o
);

  // RAW on rs1/rs2 or WAW on rd against any still-pending write.
  always_comb begin
    hazard_o = busy_i[rs1_i] | (use2_i & busy_i[rs2_i]) | (wr_i & busy_i[rd_i]);
  end

endmodule : hazard_check

// File: rtl/issue_scoreboard.sv
// In-order dual-issue scoreboard: tracks pending register writes, gates
// issue of an older/younger instruction pair, and supports a drain handshake.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 drain_req,
  input  logic                 vld0,
  input  logic                 vld1,
  input  logic [REG_IDX_W-1:0] rd0,
  input  logic [REG_IDX_W-1:0] rs1_0,
  input  logic [REG_IDX_W-1:0] rs2_0,
  input  logic [REG_IDX_W-1:0] rd1,
  input  logic [REG_IDX_W-1:0] rs1_1,
  input  logic [REG_IDX_W-1:0] rs2_1,
  input  logic                 use2_0,
  input  logic                 use2_1,
  input  logic                 wr0,
  input  logic                 wr1,
  input  logic                 wb_vld0,
  input  logic                 wb_vld1,
  input  logic [REG_IDX_W-1:0] wb_rd0,
  input  logic [REG_IDX_W-1:0] wb_rd1,
  output logic                 issue0,
  output logic                 issue1,
  output logic                 stall,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 drained,
  output logic [CNT_W-1:0]     stall_cnt
);

  state_e               state_q, state_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic                 drained_q, drained_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hazard0, hazard1, pair_dep, run;

  hazard_check #(.NUM_REGS(NUM_REGS)) u_hz0 (
    .busy_i  (busy_q),
    .rs1_i   (rs1_0),
    .rs2_i   (rs2_0),
    .rd_i    (rd0),
    .use2_i  (use2_0),
    .wr_i    (wr0),
    .hazard_o(hazard0)
  );

  hazard_check #(.NUM_REGS(NUM_REGS)) u_hz1 (
    .busy_i  (busy_q),
    .rs1_i   (rs1_1),
    .rs2_i   (rs2_1),
    .rd_i    (rd1),
    .use2_i  (use2_1),
    .wr_i    (wr1),
    .hazard_o(hazard1)
  );

  // Issue gating: lane 1 only issues alongside lane 0 and never depends on it.
  always_comb begin
    run      = (state_q == ST_RUN);
    pair_dep = wr0 & ((rs1_1 == rd0) | (use2_1 & (rs2_1 == rd0)) | (wr1 & (rd1 == rd0)));
    issue0   = vld0 & ~hazard0 & ~flush & run;
    issue1   = vld1 & issue0 & ~hazard1 & ~pair_dep;
    stall    = run & ~flush & ((vld0 & ~issue0) | (vld1 & ~issue1));
  end

  // Next pending-write vector: writebacks clear first, new issues set after.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ((wb_vld0 && (wb_rd0 == REG_IDX_W'(i))) || (wb_vld1 && (wb_rd1 == REG_IDX_W'(i))))
        busy_d[i] = 1'b0;
      if ((issue0 && wr0 && (rd0 == REG_IDX_W'(i))) || (issue1 && wr1 && (rd1 == REG_IDX_W'(i))))
        busy_d[i] = 1'b1;
    end
  end

  // Drain FSM next state; an aborted drain returns straight to RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req)       state_d = ST_RUN;
        else if (busy_d == '0) state_d = ST_DONE;
      end
      ST_DONE:  if (!drain_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    drained_d = (state_d == ST_DONE);
  end

  // Saturating stall counter next value.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      busy_q    <= '0;
      drained_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      drained_q <= drained_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign drained   = drained_q;
  assign stall_cnt = cnt_q;

endmodule : issue_scoreboard

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: table of vectors with a
// scoreboard queue for registered results, plus reset/saturation sequences.
module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush, drain_req, vld0, vld1, use2_0, use2_1, wr0, wr1;
  logic [2:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1, wb_rd0, wb_rd1;
  logic       wb_vld0, wb_vld1;
  logic       issue0, issue1, stall, drained;
  logic [7:0] busy;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  issue_scoreboard #(.NUM_REGS(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .drain_req(drain_req),
    .vld0(vld0), .vld1(vld1), .rd0(rd0), .rs1_0(rs1_0), .rs2_0(rs2_0),
    .rd1(rd1), .rs1_1(rs1_1), .rs2_1(rs2_1), .use2_0(use2_0), .use2_1(use2_1),
    .wr0(wr0), .wr1(wr1), .wb_vld0(wb_vld0), .wb_vld1(wb_vld1),
    .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .issue0(issue0), .issue1(issue1),
    .stall(stall), .busy(busy), .drained(drained), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [2:0] rd, rs1, rs2;
    logic       use2, wr;
  } lane_t;

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
  } wb_t;

  typedef struct packed {
    logic       fl, dr;
    lane_t      l0, l1;
    wb_t        w0, w1;
    logic       ei0, ei1, est;
    logic [7:0] ebusy;
    logic       edr;
  } vec_t;

  typedef struct packed {
    logic [7:0] busy;
    logic       drained;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic lane_t ln(logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2,
                               logic use2, logic wr);
    lane_t l;
    l.v = 1'b1; l.rd = rd; l.rs1 = rs1; l.rs2 = rs2; l.use2 = use2; l.wr = wr;
    return l;
  endfunction

  function automatic wb_t wb(logic [2:0] rd);
    wb_t w;
    w.v = 1'b1; w.rd = rd;
    return w;
  endfunction

  function automatic vec_t mk(logic fl, logic dr, lane_t l0, lane_t l1, wb_t w0, wb_t w1,
                              logic ei0, logic ei1, logic est, logic [7:0] ebusy, logic edr);
    vec_t v;
    v.fl = fl; v.dr = dr; v.l0 = l0; v.l1 = l1; v.w0 = w0; v.w1 = w1;
    v.ei0 = ei0; v.ei1 = ei1; v.est = est; v.ebusy = ebusy; v.edr = edr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    flush = v.fl; drain_req = v.dr;
    vld0 = v.l0.v; rd0 = v.l0.rd; rs1_0 = v.l0.rs1; rs2_0 = v.l0.rs2;
    use2_0 = v.l0.use2; wr0 = v.l0.wr;
    vld1 = v.l1.v; rd1 = v.l1.rd; rs1_1 = v.l1.rs1; rs2_1 = v.l1.rs2;
    use2_1 = v.l1.use2; wr1 = v.l1.wr;
    wb_vld0 = v.w0.v; wb_rd0 = v.w0.rd; wb_vld1 = v.w1.v; wb_rd1 = v.w1.rd;
  endtask

  task automatic pop_check(int idx);
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("busy[v%0d]", idx), 32'(busy), 32'(e.busy));
      chk($sformatf("drained[v%0d]", idx), 32'(drained), 32'(e.drained));
    end
  endtask

  initial begin
    lane_t NL;
    wb_t   NW;
    vec_t  idle;
    NL = '0;
    NW = '0;
    idle = '0;

    // columns: flush, drain, lane0, lane1, wb0, wb1, issue0, issue1, stall, busy next, drained next
    vecs.push_back(mk(0,0, ln(3,1,0,0,1), NL,          NW,     NW,     1,0,0, 8'h08, 0));
    vecs.push_back(mk(0,0, ln(4,3,0,0,0), NL,          wb(3),  NW,     0,0,1, 8'h00, 0));
    vecs.push_back(mk(0,0, ln(4,3,0,0,0), NL,          NW,     NW,     1,0,0, 8'h00, 0));
    vecs.push_back(mk(0,0, ln(2,0,0,0,1), ln(5,2,0,0,1), NW,   NW,     1,0,1, 8'h04, 0));
    vecs.push_back(mk(0,0, ln(5,2,0,0,1), NL,          wb(2),  NW,     0,0,1, 8'h00, 0));
    vecs.push_back(mk(0,0, ln(5,2,0,0,1), NL,          NW,     NW,     1,0,0, 8'h20, 0));
    vecs.push_back(mk(0,0, ln(1,0,0,0,1), ln(6,0,7,1,1), NW,   NW,     1,1,0, 8'h62, 0));
    vecs.push_back(mk(0,0, NL,            NL,          wb(5),  wb(5),  0,0,0, 8'h42, 0));
    vecs.push_back(mk(0,0, NL,            NL,          wb(0),  wb(1),  0,0,0, 8'h40, 0));
    vecs.push_back(mk(1,0, ln(0,2,0,0,1), ln(3,4,0,0,1), NW,   NW,     0,0,0, 8'h40, 0));
    vecs.push_back(mk(0,0, ln(2,0,0,0,1), NL,          wb(2),  NW,     1,0,0, 8'h44, 0));
    vecs.push_back(mk(0,0, ln(1,0,0,0,1), ln(0,0,6,1,0), NW,   NW,     1,0,1, 8'h46, 0));
    vecs.push_back(mk(0,0, ln(0,0,6,0,0), ln(3,0,2,0,1), NW,   NW,     1,1,0, 8'h4E, 0));
    vecs.push_back(mk(0,0, ln(1,0,0,0,1), NL,          NW,     NW,     0,0,1, 8'h4E, 0));
    vecs.push_back(mk(0,0, NL,            NL,          wb(1),  wb(2),  0,0,0, 8'h48, 0));
    vecs.push_back(mk(0,0, NL,            NL,          wb(3),  wb(6),  0,0,0, 8'h00, 0));
    vecs.push_back(mk(0,0, ln(7,0,0,0,1), ln(7,0,0,0,1), NW,   NW,     1,0,1, 8'h80, 0));
    vecs.push_back(mk(0,0, NL,            NL,          wb(7),  NW,     0,0,0, 8'h00, 0));
    vecs.push_back(mk(0,0, ln(0,1,0,0,1), ln(2,1,0,0,1), NW,   NW,     1,1,0, 8'h05, 0));
    // drain: enter, retire r0 then r2, hold DONE, release, run again
    vecs.push_back(mk(0,1, NL,            NL,          NW,     NW,     0,0,0, 8'h05, 0));
    vecs.push_back(mk(0,1, ln(4,1,0,0,1), NL,          wb(0),  NW,     0,0,0, 8'h04, 0));
    vecs.push_back(mk(0,1, NL,            NL,          wb(2),  NW,     0,0,0, 8'h00, 1));
    vecs.push_back(mk(0,1, ln(4,1,0,0,1), NL,          NW,     NW,     0,0,0, 8'h00, 1));
    vecs.push_back(mk(0,0, ln(4,1,0,0,1), NL,          NW,     NW,     0,0,0, 8'h00, 0));
    vecs.push_back(mk(0,0, ln(4,1,0,0,1), NL,          NW,     NW,     1,0,0, 8'h10, 0));
    // drain aborted before completion
    vecs.push_back(mk(0,1, NL,            NL,          NW,     NW,     0,0,0, 8'h10, 0));
    vecs.push_back(mk(0,0, ln(5,0,0,0,1), NL,          NW,     NW,     0,0,0, 8'h10, 0));
    vecs.push_back(mk(0,0, ln(5,0,0,0,1), NL,          NW,     NW,     1,0,0, 8'h30, 0));

    reset = 1'b1;
    apply(idle);
    #12;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_drained", 32'(drained), 32'h0);
    chk("reset_cnt", 32'(stall_cnt), 32'h0);
    chk("reset_issue0", 32'(issue0), 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      pop_check(i - 1);
      apply(vecs[i]);
      #2;
      chk($sformatf("issue0[v%0d]", i), 32'(issue0), 32'(vecs[i].ei0));
      chk($sformatf("issue1[v%0d]", i), 32'(issue1), 32'(vecs[i].ei1));
      chk($sformatf("stall[v%0d]", i), 32'(stall), 32'(vecs[i].est));
      sb.push_back({vecs[i].ebusy, vecs[i].edr});
    end
    @(posedge clk);
    #1;
    pop_check(vecs.size() - 1);
    apply(idle);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("stall_cnt_table", 32'(stall_cnt), 32'd6);

    // reset in the middle of a drain forgets pending writes and returns to RUN
    drain_req = 1'b1;
    @(posedge clk);
    #1;
    chk("middrain_busy", 32'(busy), 32'h30);
    chk("middrain_issue_blocked", 32'(issue0), 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(busy), 32'h0);
    chk("async_reset_cnt", 32'(stall_cnt), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    drain_req = 1'b0;
    vld0 = 1'b1; rd0 = 3'd7; rs1_0 = 3'd0; wr0 = 1'b1;
    #1;
    chk("post_reset_issue0", 32'(issue0), 32'h1);
    @(posedge clk);
    #1;
    chk("post_reset_busy", 32'(busy), 32'h80);

    // long stall on r7 to drive the counter into saturation
    rd0 = 3'd0; rs1_0 = 3'd7; wr0 = 1'b0;
    #1;
    chk("hold_stall", 32'(stall), 32'h1);
    repeat (100) @(posedge clk);
    #1;
    chk("cnt_100", 32'(stall_cnt), 32'd100);
    repeat (69900) @(posedge clk);
    #1;
    chk("cnt_sat", 32'(stall_cnt), 32'hFFFF);
    chk("still_stall", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    chk("cnt_no_wrap", 32'(stall_cnt), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_issue_scoreboard
